// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: PS/2 device-to-host frame receiver with scan-code prefix decoding into key events
module ps2_rx_frame #(
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       frame_err,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_make,
    output logic       key_break
);
    localparam int WW = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]    clk_s, dat_s;
    logic [3:0]    fcnt;
    logic          filt, fall, d, par, ext_pend, brk_pend, ign;
    logic [2:0]    bcnt;
    logic [7:0]    shreg;
    logic [WW-1:0] wd;
    state_t        state;

    assign d    = dat_s[1];
    assign fall = filt && !clk_s[1] && fcnt == 4'(FILTER_LEN - 1);
    assign ign  = byte_data inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};

    // two-stage synchronizers for the asynchronous pins, idle high
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s <= 2'b11;
            dat_s <= 2'b11;
        end else begin
            clk_s <= {clk_s[0], ps2_clk_in};
            dat_s <= {dat_s[0], ps2_data_in};
        end
    end

    // glitch filter: the level flips only after FILTER_LEN consecutive opposite samples
    always_ff @(posedge clk) begin
        if (rst) begin
            fcnt <= '0;
            filt <= 1'b1;
        end else if (clk_s[1] == filt) begin
            fcnt <= '0;
        end else if (fcnt == 4'(FILTER_LEN - 1)) begin
            filt <= clk_s[1];
            fcnt <= '0;
        end else begin
            fcnt <= fcnt + 4'd1;
        end
    end

    // frame FSM with watchdog; a timeout drops the partial byte and reports an error
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            bcnt       <= '0;
            par        <= 1'b0;
            wd         <= '0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            wd         <= (state == IDLE || fall) ? '0 : wd + 1'b1;
            if (state != IDLE && !fall && wd == WW'(TIMEOUT_CYC - 1)) begin
                frame_err <= 1'b1;
                state     <= IDLE;
                shreg     <= '0;
                wd        <= '0;
            end else if (fall) begin
                case (state)
                    IDLE: begin
                        state <= d ? IDLE : DATA;
                        bcnt  <= '0;
                    end
                    DATA: begin
                        shreg <= {d, shreg[7:1]};
                        bcnt  <= bcnt + 3'd1;
                        state <= (bcnt == 3'd7) ? PARITY : DATA;
                    end
                    PARITY: begin
                        par   <= d;
                        state <= STOP;
                    end
                    default: begin
                        if (d && (^shreg ^ par)) begin
                            byte_valid <= 1'b1;
                            byte_data  <= shreg;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    // prefix decoder: E0/F0 set pendings, status bytes pass through, others emit key events
    always_ff @(posedge clk) begin
        if (rst) begin
            ext_pend  <= 1'b0;
            brk_pend  <= 1'b0;
            key_code  <= '0;
            key_ext   <= 1'b0;
            key_make  <= 1'b0;
            key_break <= 1'b0;
        end else begin
            key_make  <= 1'b0;
            key_break <= 1'b0;
            if (frame_err) begin
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
            end else if (byte_valid) begin
                if (byte_data == 8'hE0) begin
                    ext_pend <= 1'b1;
                end else if (byte_data == 8'hF0) begin
                    brk_pend <= 1'b1;
                end else if (!ign) begin
                    key_code  <= byte_data;
                    key_ext   <= ext_pend;
                    key_make  <= !brk_pend;
                    key_break <= brk_pend;
                    ext_pend  <= 1'b0;
                    brk_pend  <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_ps2_rx_frame.sv
// tb_ps2_rx_frame: directed frame scenarios with hand-computed expectations for ps2_rx_frame
module tb_ps2_rx_frame;
    localparam int FL = 4;
    localparam int TO = 300;
    localparam int HP = 20;

    logic       clk = 1'b0, rst = 1'b1, pc = 1'b1, pd = 1'b1;
    logic [7:0] byte_data, key_code;
    logic       byte_valid, frame_err, key_ext, key_make, key_break;

    ps2_rx_frame #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .ps2_clk_in(pc), .ps2_data_in(pd),
        .byte_data(byte_data), .byte_valid(byte_valid), .frame_err(frame_err),
        .key_code(key_code), .key_ext(key_ext), .key_make(key_make), .key_break(key_break)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nbv = 0, nfe = 0, nmk = 0, nbk = 0, nboth = 0;
    int bv_cyc = 0, fe_cyc = 0, mk_cyc = 0, last_fall = 0;
    int checks = 0, passed = 0;
    int s_bv, s_fe, s_mk, s_bk;

    // event monitor sampled away from the active edge
    always @(negedge clk) begin
        if (byte_valid) begin nbv++; bv_cyc = cyc; end
        if (frame_err) begin nfe++; fe_cyc = cyc; end
        if (key_make) begin nmk++; mk_cyc = cyc; end
        if (key_break) nbk++;
        if (byte_valid && frame_err) nboth++;
    end

    task automatic snap();
        s_bv = nbv; s_fe = nfe; s_mk = nmk; s_bk = nbk;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad, input int nb, input int gl);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad, b, 1'b0};
        for (int i = 0; i < nb; i++) begin
            @(negedge clk); pd = f[i];
            repeat (HP/2) @(negedge clk);
            pc = 1'b0; last_fall = cyc;
            repeat (HP) @(negedge clk);
            pc = 1'b1;
            if (i == gl) begin
                repeat (3) @(negedge clk); pc = 1'b0;
                repeat (FL-1) @(negedge clk); pc = 1'b1;
            end
            repeat (HP/2) @(negedge clk);
        end
        pd = 1'b1;
        repeat (30) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (5) @(negedge clk);
        checks++; if (byte_data !== 8'h00) $display("FAIL reset byte_data: got %h want 00", byte_data); else passed++;
        checks++; if ({byte_valid, frame_err, key_make, key_break, key_ext} !== 5'b0) $display("FAIL reset pulses: got %b want 00000", {byte_valid, frame_err, key_make, key_break, key_ext}); else passed++;
        checks++; if (key_code !== 8'h00) $display("FAIL reset key_code: got %h want 00", key_code); else passed++;
        rst = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_make();
        snap();
        send_frame(8'h1D, 0, 11, -1);
        checks++; if (nbv - s_bv !== 1) $display("FAIL make byte_valid count: got %0d want 1", nbv - s_bv); else passed++;
        checks++; if (byte_data !== 8'h1D) $display("FAIL make byte_data: got %h want 1d", byte_data); else passed++;
        checks++; if (bv_cyc - last_fall !== FL + 2) $display("FAIL make byte_valid latency: got %0d want %0d", bv_cyc - last_fall, FL + 2); else passed++;
        checks++; if (mk_cyc - bv_cyc !== 1) $display("FAIL make key_make latency: got %0d want 1", mk_cyc - bv_cyc); else passed++;
        checks++; if (nmk - s_mk !== 1 || nbk != s_bk) $display("FAIL make events: got make %0d break %0d want 1 0", nmk - s_mk, nbk - s_bk); else passed++;
        checks++; if ({key_ext, key_code} !== 9'h01D) $display("FAIL make key: got ext %b code %h want 0 1d", key_ext, key_code); else passed++;
    endtask

    task automatic test_break();
        snap();
        send_frame(8'hF0, 0, 11, -1);
        checks++; if (nmk - s_mk + nbk - s_bk !== 0) $display("FAIL break F0 event: got %0d want 0", nmk - s_mk + nbk - s_bk); else passed++;
        send_frame(8'h1D, 0, 11, -1);
        checks++; if (nbv - s_bv !== 2) $display("FAIL break byte_valid count: got %0d want 2", nbv - s_bv); else passed++;
        checks++; if (nbk - s_bk !== 1 || nmk != s_mk) $display("FAIL break events: got break %0d make %0d want 1 0", nbk - s_bk, nmk - s_mk); else passed++;
        checks++; if ({key_ext, key_code} !== 9'h01D) $display("FAIL break key: got ext %b code %h want 0 1d", key_ext, key_code); else passed++;
    endtask

    task automatic test_ext_break();
        snap();
        send_frame(8'hE0, 0, 11, -1);
        send_frame(8'hF0, 0, 11, -1);
        send_frame(8'h75, 0, 11, -1);
        checks++; if (nbk - s_bk !== 1 || nmk != s_mk) $display("FAIL ext_break events: got break %0d make %0d want 1 0", nbk - s_bk, nmk - s_mk); else passed++;
        checks++; if ({key_ext, key_code} !== 9'h175) $display("FAIL ext_break key: got ext %b code %h want 1 75", key_ext, key_code); else passed++;
        snap();
        send_frame(8'h75, 0, 11, -1);
        checks++; if (nmk - s_mk !== 1 || nbk != s_bk) $display("FAIL ext_make events: got make %0d break %0d want 1 0", nmk - s_mk, nbk - s_bk); else passed++;
        checks++; if ({key_ext, key_code} !== 9'h075) $display("FAIL ext_make key: got ext %b code %h want 0 75", key_ext, key_code); else passed++;
    endtask

    task automatic test_ignore();
        snap();
        send_frame(8'hF0, 0, 11, -1);
        send_frame(8'hAA, 0, 11, -1);
        send_frame(8'hFA, 0, 11, -1);
        checks++; if (nmk - s_mk + nbk - s_bk !== 0) $display("FAIL ignore status event: got %0d want 0", nmk - s_mk + nbk - s_bk); else passed++;
        send_frame(8'h1D, 0, 11, -1);
        checks++; if (nbk - s_bk !== 1 || nbv - s_bv !== 4) $display("FAIL ignore pending kept: got break %0d bytes %0d want 1 4", nbk - s_bk, nbv - s_bv); else passed++;
    endtask

    task automatic test_parity();
        snap();
        send_frame(8'h29, 1, 11, -1);
        checks++; if (nfe - s_fe !== 1 || nbv != s_bv) $display("FAIL parity err: got err %0d bytes %0d want 1 0", nfe - s_fe, nbv - s_bv); else passed++;
        checks++; if (byte_data !== 8'h1D) $display("FAIL parity byte_data held: got %h want 1d", byte_data); else passed++;
        send_frame(8'h5A, 0, 11, -1);
        checks++; if (nmk - s_mk !== 1 || key_code !== 8'h5A) $display("FAIL parity recover: got make %0d code %h want 1 5a", nmk - s_mk, key_code); else passed++;
    endtask

    task automatic test_timeout();
        send_frame(8'hE0, 0, 11, -1);
        snap();
        send_frame(8'h12, 0, 6, -1);
        repeat (TO + 40) @(negedge clk);
        checks++; if (nfe - s_fe !== 1 || nbv != s_bv) $display("FAIL timeout err: got err %0d bytes %0d want 1 0", nfe - s_fe, nbv - s_bv); else passed++;
        checks++; if (fe_cyc - last_fall !== FL + 2 + TO) $display("FAIL timeout latency: got %0d want %0d", fe_cyc - last_fall, FL + 2 + TO); else passed++;
        snap();
        send_frame(8'hF0, 0, 11, -1);
        send_frame(8'h76, 0, 11, -1);
        checks++; if (nbk - s_bk !== 1 || nmk != s_mk) $display("FAIL timeout break events: got break %0d make %0d want 1 0", nbk - s_bk, nmk - s_mk); else passed++;
        checks++; if ({key_ext, key_code} !== 9'h076) $display("FAIL timeout key: got ext %b code %h want 0 76", key_ext, key_code); else passed++;
    endtask

    task automatic test_glitch();
        snap();
        pd = 1'b0;
        repeat (5) @(negedge clk); pc = 1'b0;
        repeat (FL-1) @(negedge clk); pc = 1'b1;
        repeat (5) @(negedge clk); pd = 1'b1;
        repeat (TO + 50) @(negedge clk);
        checks++; if (nfe - s_fe + nbv - s_bv !== 0) $display("FAIL idle glitch: got %0d events want 0", nfe - s_fe + nbv - s_bv); else passed++;
        send_frame(8'h1C, 0, 11, 3);
        checks++; if (nmk - s_mk !== 1 || key_code !== 8'h1C || nfe != s_fe) $display("FAIL data glitch: got make %0d code %h err %0d want 1 1c 0", nmk - s_mk, key_code, nfe - s_fe); else passed++;
    endtask

    task automatic test_rst_mid();
        snap();
        send_frame(8'h33, 0, 4, -1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (TO + 50) @(negedge clk);
        checks++; if (nfe - s_fe + nbv - s_bv !== 0) $display("FAIL rst mid-frame: got %0d events want 0", nfe - s_fe + nbv - s_bv); else passed++;
        send_frame(8'h16, 0, 11, -1);
        checks++; if (nmk - s_mk !== 1 || {key_ext, key_code} !== 9'h016) $display("FAIL rst recover: got make %0d ext %b code %h want 1 0 16", nmk - s_mk, key_ext, key_code); else passed++;
    endtask

    initial begin
        test_reset();
        test_make();
        test_break();
        test_ext_break();
        test_ignore();
        test_parity();
        test_timeout();
        test_glitch();
        test_rst_mid();
        checks++; if (nboth !== 0) $display("FAIL byte_valid with frame_err: got %0d want 0", nboth); else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
